// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: register file sizes, ROB geometry and
// the reorder-buffer entry layout.
package ooo_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PHYS_W        = $clog2(NUM_PHYS_REGS);
    localparam int ARCH_W        = $clog2(NUM_ARCH_REGS);
    localparam int ROB_DEPTH     = 16;
    localparam int TAG_W         = $clog2(ROB_DEPTH);

    localparam logic [PHYS_W-1:0] INVALID_REG = 6'h3F;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_rd;
        logic [ARCH_W-1:0] rd;
        logic [PHYS_W-1:0] phys_rd;
        logic [PHYS_W-1:0] old_phys_rd;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at dispatch, marks done on writeback,
// retires one entry per cycle and hands the old physical rd back to rename.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4,
    parameter int PHYS_W    = 6,
    parameter int ARCH_W    = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dispatch_valid,
    input  logic              dispatch_has_rd,
    input  logic [ARCH_W-1:0] dispatch_rd,
    input  logic [PHYS_W-1:0] dispatch_phys_rd,
    input  logic [PHYS_W-1:0] dispatch_old_phys_rd,
    output logic [TAG_W-1:0]  dispatch_tag,
    output logic              rob_full,
    output logic              rob_empty,
    output logic [TAG_W:0]    count,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    output logic              commit_valid,
    output logic [ARCH_W-1:0] commit_rd,
    output logic [PHYS_W-1:0] commit_phys_rd,
    output logic              retire_valid,
    output logic [PHYS_W-1:0] retire_phys_reg
);
    import ooo_pkg::*;

    localparam int PTR_W = TAG_W + 1;

    rob_entry_t        r_rob [ROB_DEPTH];
    logic [PTR_W-1:0]  r_head, r_tail;
    logic              r_commit_valid, r_retire_valid;
    logic [ARCH_W-1:0] r_commit_rd;
    logic [PHYS_W-1:0] r_commit_phys_rd, r_retire_phys_reg;

    logic [PTR_W-1:0]  w_count;
    logic [TAG_W-1:0]  w_head_idx, w_tail_idx;
    logic              w_full, w_empty, w_disp_fire, w_retire;
    rob_entry_t        w_head_ent, w_new_ent;

    // Pointers carry a wrap bit, so full and empty fall out of the difference.
    assign w_count     = r_tail - r_head;
    assign w_full      = (w_count == PTR_W'(ROB_DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_head_idx  = r_head[TAG_W-1:0];
    assign w_tail_idx  = r_tail[TAG_W-1:0];
    assign w_head_ent  = r_rob[w_head_idx];
    assign w_retire    = w_head_ent.valid && w_head_ent.done;
    assign w_disp_fire = dispatch_valid && !w_full;

    always_comb begin
        w_new_ent             = '0;
        w_new_ent.valid       = 1'b1;
        w_new_ent.has_rd      = dispatch_has_rd;
        w_new_ent.rd          = dispatch_rd;
        w_new_ent.phys_rd     = dispatch_phys_rd;
        w_new_ent.old_phys_rd = dispatch_old_phys_rd;
    end

    // Tail and head never alias while both fire (that needs full or empty), so
    // the only real overlap is retire vs. writeback, where retire wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) r_rob[i] <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (w_disp_fire && w_tail_idx == TAG_W'(i)) begin
                    r_rob[i] <= w_new_ent;
                end else if (w_retire && w_head_idx == TAG_W'(i)) begin
                    r_rob[i].valid <= 1'b0;
                    r_rob[i].done  <= 1'b0;
                end else if (wb_valid && wb_tag == TAG_W'(i) && r_rob[i].valid) begin
                    r_rob[i].done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_disp_fire) r_tail <= r_tail + 1'b1;
            if (w_retire)    r_head <= r_head + 1'b1;
        end
    end

    // Payload outputs only move on a retirement; the valids pulse for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_commit_valid    <= 1'b0;
            r_retire_valid    <= 1'b0;
            r_commit_rd       <= '0;
            r_commit_phys_rd  <= '0;
            r_retire_phys_reg <= '0;
        end else begin
            r_commit_valid <= w_retire;
            r_retire_valid <= w_retire && w_head_ent.has_rd;
            if (w_retire) begin
                r_commit_rd       <= w_head_ent.rd;
                r_commit_phys_rd  <= w_head_ent.phys_rd;
                r_retire_phys_reg <= w_head_ent.old_phys_rd;
            end
        end
    end

    assign dispatch_tag    = w_tail_idx;
    assign rob_full        = w_full;
    assign rob_empty       = w_empty;
    assign count           = w_count;
    assign commit_valid    = r_commit_valid;
    assign commit_rd       = r_commit_rd;
    assign commit_phys_rd  = r_commit_phys_rd;
    assign retire_valid    = r_retire_valid;
    assign retire_phys_reg = r_retire_phys_reg;
endmodule
